// File: rtl/sensor_timing_gen_if.sv
// Parallel-sensor generator bus: configuration inputs plus the
// fval/lval/pixel stream produced by sensor_timing_gen.
//   master : the generator (consumes config, drives stream/status)
//   slave  : the consumer side (drives config, observes stream/status)
// Signals:
//   i_gen_en, i_width, i_height, i_h_blank, i_v_blank, i_pattern_sel
//   o_fval, o_lval, o_pix_data, o_frame_cnt, o_busy
interface sensor_timing_gen_if #(
   parameter int DATA_WIDTH = 10,
   parameter int REG_WD     = 32
);
   logic                  i_gen_en;
   logic [REG_WD-1:0]     i_width;
   logic [REG_WD-1:0]     i_height;
   logic [REG_WD-1:0]     i_h_blank;
   logic [REG_WD-1:0]     i_v_blank;
   logic [1:0]            i_pattern_sel;
   logic                  o_fval;
   logic                  o_lval;
   logic [DATA_WIDTH-1:0] o_pix_data;
   logic [15:0]           o_frame_cnt;
   logic                  o_busy;

   modport master (
      input  i_gen_en, i_width, i_height, i_h_blank, i_v_blank, i_pattern_sel,
      output o_fval, o_lval, o_pix_data, o_frame_cnt, o_busy
   );

   modport slave (
      output i_gen_en, i_width, i_height, i_h_blank, i_v_blank, i_pattern_sel,
      input  o_fval, o_lval, o_pix_data, o_frame_cnt, o_busy
   );
endinterface

// File: rtl/sensor_timing_gen.sv
// Synthesizable fval/lval/pixel frame source for self-test and bring-up.
// Frames are always emitted whole; geometry and pattern are latched into
// shadow registers at each frame start.
// Ports:
//   clk   : pixel clock
//   reset : asynchronous, active-high
//   bus   : sensor_timing_gen_if.master (config in, stream/status out)
module sensor_timing_gen #(
   parameter int          DATA_WIDTH    = 10,
   parameter int          REG_WD        = 32,
   parameter int          FVAL_LVAL_GAP = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic clk,
   input  logic reset,
   sensor_timing_gen_if.master bus
);
   typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TAIL, VBLANK} state_t;

   localparam logic [15:0] GAP_LAST = 16'(FVAL_LVAL_GAP - 1);

   state_t                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [15:0]           line_q, line_d;
   logic [15:0]           width_q, width_d;
   logic [15:0]           height_q, height_d;
   logic [15:0]           hblank_q, hblank_d;
   logic [15:0]           vblank_q, vblank_d;
   logic [1:0]            pat_q, pat_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic [DATA_WIDTH-1:0] pix_q, pix_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  fval_q, fval_d;
   logic                  lval_q, lval_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  start_ok;
   logic                  latch;

   assign start_ok = bus.i_gen_en && (bus.i_width[15:0] != '0) && (bus.i_height[15:0] != '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 16'd1;
      line_d      = line_q;
      width_d     = width_q;
      height_d    = height_q;
      hblank_d    = hblank_q;
      vblank_d    = vblank_q;
      pat_d       = pat_q;
      lfsr_d      = lfsr_q;
      pix_d       = pix_q;
      frame_cnt_d = frame_cnt_q;
      latch       = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_ok) begin
               latch   = 1'b1;
               state_d = LEAD;
            end
         end
         LEAD: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = LINE;
            end
         end
         LINE: begin
            if (cnt_q == width_q - 16'd1) begin
               cnt_d = '0;
               if (line_q < height_q - 16'd1) begin
                  line_d  = line_q + 16'd1;
                  state_d = HBLANK;
               end else begin
                  state_d = TAIL;
               end
            end
         end
         HBLANK: begin
            if (cnt_q == hblank_q - 16'd1) begin
               cnt_d   = '0;
               state_d = LINE;
            end
         end
         TAIL: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d       = '0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = VBLANK;
            end
         end
         VBLANK: begin
            if (cnt_q == vblank_q - 16'd1) begin
               cnt_d = '0;
               if (start_ok) begin
                  latch   = 1'b1;
                  state_d = LEAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      if (latch) begin
         width_d  = bus.i_width[15:0];
         height_d = bus.i_height[15:0];
         hblank_d = (bus.i_h_blank[15:0] == '0) ? 16'd1 : bus.i_h_blank[15:0];
         vblank_d = (bus.i_v_blank[15:0] == '0) ? 16'd1 : bus.i_v_blank[15:0];
         pat_d    = bus.i_pattern_sel;
         line_d   = '0;
         pix_d    = '0;
         if (bus.i_pattern_sel == 2'd0) lfsr_d = LFSR_SEED;
      end

      // Outputs are registered from the next state so they line up with it.
      fval_d = state_d inside {LEAD, LINE, HBLANK, TAIL};
      lval_d = (state_d == LINE);
      busy_d = (state_d != IDLE);
      data_d = '0;
      if (lval_d) begin
         case (pat_q)
            2'd0: begin
               data_d = lfsr_q[DATA_WIDTH-1:0];
               lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end
            2'd1: data_d = cnt_d[DATA_WIDTH-1:0];
            2'd2: data_d = frame_cnt_q[DATA_WIDTH-1:0];
            default: begin
               data_d = pix_q;
               pix_d  = pix_q + DATA_WIDTH'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         line_q      <= '0;
         width_q     <= '0;
         height_q    <= '0;
         hblank_q    <= 16'd1;
         vblank_q    <= 16'd1;
         pat_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         pix_q       <= '0;
         frame_cnt_q <= '0;
         fval_q      <= 1'b0;
         lval_q      <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         line_q      <= line_d;
         width_q     <= width_d;
         height_q    <= height_d;
         hblank_q    <= hblank_d;
         vblank_q    <= vblank_d;
         pat_q       <= pat_d;
         lfsr_q      <= lfsr_d;
         pix_q       <= pix_d;
         frame_cnt_q <= frame_cnt_d;
         fval_q      <= fval_d;
         lval_q      <= lval_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.o_fval      = fval_q;
   assign bus.o_lval      = lval_q;
   assign bus.o_pix_data  = data_q;
   assign bus.o_frame_cnt = frame_cnt_q;
   assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_sensor_timing_gen.sv
// Scoreboard bench for sensor_timing_gen: stimulus pushes expected frame,
// line and pixel records; the monitor pops and compares as the stream appears.
module tb_sensor_timing_gen;
   localparam int DW  = 10;
   localparam int GAP = 3;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   sensor_timing_gen_if #(.DATA_WIDTH(DW), .REG_WD(32)) bus ();

   sensor_timing_gen #(
      .DATA_WIDTH(DW), .REG_WD(32), .FVAL_LVAL_GAP(GAP), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   int vectors = 0;
   int miscompares = 0;
   bit sb_on = 1'b0;
   int fcnt = 0;

   logic [DW-1:0] exp_pix[$];
   int            exp_lval[$];
   int            exp_fval[$];

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int w, input int h, input int hb, input int pat, input int fc);
      logic [15:0] l = 16'hACE1;
      int k = 0;
      int hbe = (hb == 0) ? 1 : hb;
      exp_fval.push_back(2 * GAP + w * h + (h - 1) * hbe);
      for (int y = 0; y < h; y++) begin
         exp_lval.push_back(w);
         for (int c = 0; c < w; c++) begin
            case (pat)
               0: begin
                  exp_pix.push_back(l[DW-1:0]);
                  l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
               end
               1: exp_pix.push_back(DW'(c));
               2: exp_pix.push_back(DW'(fc));
               default: exp_pix.push_back(DW'(k));
            endcase
            k++;
         end
      end
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 20000 && bus.o_busy; t++) @(negedge clk);
      check("busy_drop", bus.o_busy, 0);
   endtask

   // Runs n frames; if w2 differs from w, the width input is changed right
   // after the first fval rise and only later frames use it.
   task automatic run_frames(input int n, input int w, input int h, input int hb, input int vb,
                             input int pat, input int w2, output int period);
      int rises = 1;
      int r1 = 0;
      int r2 = 0;
      bit pf;
      for (int i = 0; i < n; i++) push_frame((i == 0) ? w : w2, h, hb, pat, fcnt + i);
      bus.i_width = w; bus.i_height = h; bus.i_h_blank = hb; bus.i_v_blank = vb;
      bus.i_pattern_sel = 2'(pat);
      @(negedge clk);
      bus.i_gen_en = 1'b1;
      @(negedge clk);
      check("fval_1clk_after_en", bus.o_fval, 1);
      bus.i_width = w2;
      r2 = cyc;
      pf = bus.o_fval;
      for (int t = 0; t < 40000 && rises < n; t++) begin
         @(negedge clk);
         if (bus.o_fval && !pf) begin
            rises++;
            r1 = r2;
            r2 = cyc;
         end
         pf = bus.o_fval;
      end
      check("frame_starts", rises, n);
      bus.i_gen_en = 1'b0;
      period = (n > 1) ? (r2 - r1) : 0;
      wait_idle();
      fcnt += n;
      check("frame_cnt", bus.o_frame_cnt, fcnt);
   endtask

   // Monitor
   int fl = 0;
   int ll = 0;
   bit mpf = 1'b0;
   bit mpl = 1'b0;
   bit lead = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         fl = 0; ll = 0; mpf = 1'b0; mpl = 1'b0; lead = 1'b0;
      end else begin
         if (bus.o_fval) fl++;
         if (bus.o_lval) ll++;
         if (bus.o_fval && !mpf) lead = 1'b1;
         if (sb_on) begin
            if (bus.o_lval) begin
               if (lead) check("lead_gap", fl - 1, GAP);
               if (exp_pix.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL pix: unexpected pixel %0d, expected none", bus.o_pix_data);
               end else begin
                  check("pix", bus.o_pix_data, exp_pix.pop_front());
               end
            end else begin
               check("blank_data_zero", bus.o_pix_data, 0);
            end
            if (!bus.o_lval && mpl) begin
               if (exp_lval.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL lval_len: unexpected line of %0d, expected none", ll);
               end else check("lval_len", ll, exp_lval.pop_front());
            end
            if (!bus.o_fval && mpf) begin
               if (exp_fval.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL fval_len: unexpected frame of %0d, expected none", fl);
               end else check("fval_len", fl, exp_fval.pop_front());
            end
         end
         if (bus.o_lval) lead = 1'b0;
         if (!bus.o_lval) ll = 0;
         if (!bus.o_fval) fl = 0;
         mpf = bus.o_fval;
         mpl = bus.o_lval;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int cf;
      int cr;
      bit seen;
      reset = 1'b1;
      bus.i_gen_en = 1'b0; bus.i_width = '0; bus.i_height = '0;
      bus.i_h_blank = '0; bus.i_v_blank = '0; bus.i_pattern_sel = 2'd3;
      repeat (3) @(negedge clk);
      check("rst_fval", bus.o_fval, 0);
      check("rst_lval", bus.o_lval, 0);
      check("rst_pix", bus.o_pix_data, 0);
      check("rst_frame_cnt", bus.o_frame_cnt, 0);
      check("rst_busy", bus.o_busy, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_fval", bus.o_fval, 0);

      // Reset in the middle of a line.
      bus.i_width = 64; bus.i_height = 4; bus.i_h_blank = 4; bus.i_v_blank = 4;
      bus.i_gen_en = 1'b1;
      for (int t = 0; t < 200 && !bus.o_lval; t++) @(negedge clk);
      check("lval_before_reset", bus.o_lval, 1);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_fval", bus.o_fval, 0);
      check("midrst_lval", bus.o_lval, 0);
      check("midrst_pix", bus.o_pix_data, 0);
      check("midrst_frame_cnt", bus.o_frame_cnt, 0);
      check("midrst_busy", bus.o_busy, 0);
      bus.i_gen_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Zero width never starts a frame.
      bus.i_width = 0; bus.i_height = 3; bus.i_gen_en = 1'b1;
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (bus.o_fval) seen = 1'b1;
      end
      check("width0_no_fval", seen, 0);
      check("width0_busy", bus.o_busy, 0);
      bus.i_gen_en = 1'b0;
      @(negedge clk);

      sb_on = 1'b1;
      run_frames(2, 4, 3, 2, 5, 3, 4, p);              // PIX_INC 0..11, restart
      run_frames(2, 64, 64, 16, 100, 3, 64, p);        // 5110-clock fval
      check("frame_period", p, 5210);

      // Drop enable mid-frame, raise it again during vblank.
      push_frame(8, 4, 2, 3, fcnt);
      push_frame(8, 4, 2, 3, fcnt + 1);
      bus.i_width = 8; bus.i_height = 4; bus.i_h_blank = 2; bus.i_v_blank = 20;
      bus.i_pattern_sel = 2'd3;
      @(negedge clk);
      bus.i_gen_en = 1'b1;
      @(negedge clk);
      check("drop_fval_start", bus.o_fval, 1);
      repeat (21) @(negedge clk);
      bus.i_gen_en = 1'b0;
      for (int t = 0; t < 1000 && bus.o_fval; t++) @(negedge clk);
      check("drop_fval_fell", bus.o_fval, 0);
      cf = cyc;
      repeat (5) @(negedge clk);
      bus.i_gen_en = 1'b1;
      for (int t = 0; t < 1000 && !bus.o_fval; t++) @(negedge clk);
      cr = cyc;
      check("vblank_len", cr - cf, 20);
      bus.i_gen_en = 1'b0;
      wait_idle();
      fcnt += 2;
      check("frame_cnt", bus.o_frame_cnt, fcnt);

      run_frames(2, 64, 2, 0, 3, 3, 32, p);            // width 64->32, h_blank 0
      run_frames(1, 2000, 2, 3, 4, 1, 2000, p);        // LINE_INC wrap
      run_frames(2, 3, 2, 1, 2, 2, 3, p);              // FRAME_INC
      run_frames(2, 5, 2, 1, 2, 0, 5, p);              // RANDOM, reseeded per frame
      run_frames(30 - fcnt, 2, 1, 1, 1, 3, 2, p);
      check("frame_cnt_30", bus.o_frame_cnt, 30);

      repeat (3) @(negedge clk);
      check("pix_queue_empty", exp_pix.size(), 0);
      check("lval_queue_empty", exp_lval.size(), 0);
      check("fval_queue_empty", exp_fval.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
